// File: rtl/difftest_uart_in_responder.sv
// Difftest UART-input responder: FIFO-backed getc server with zero-latency response.
// Optional macro UART_IN_LOOPBACK_EN echoes DUT putc bytes back into the FIFO.
module difftest_uart_in_responder #(
  parameter int          DEPTH    = 16,
  parameter logic [7:0]  EMPTY_CH = 8'hFF,
  parameter int          CW       = 32
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push_valid,
  output logic                     push_ready,
  input  logic [7:0]               push_data,
  input  logic                     uart_in_valid,
  output logic [7:0]               uart_in_ch,
  input  logic                     uart_out_valid,
  input  logic [7:0]               uart_out_ch,
  output logic [$clog2(DEPTH):0]   count,
  output logic [CW-1:0]            underflow_cnt,
  output logic [CW-1:0]            drop_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   PtrOne = 1;
  localparam logic [CW-1:0] CntOne = 1;

  logic [AW:0]   rdPtr_q, rdPtr_d, wrPtr_q, wrPtr_d;
  logic [CW-1:0] underflowCnt_q, underflowCnt_d;
  logic [7:0]    mem_q [DEPTH];
  logic          empty, full, doPop, doWrite, doDrop;
  logic [7:0]    wrData;

  assign empty = (rdPtr_q == wrPtr_q);
  assign full  = (rdPtr_q[AW] != wrPtr_q[AW]) && (rdPtr_q[AW-1:0] == wrPtr_q[AW-1:0]);
  assign doPop = uart_in_valid & ~empty;

`ifdef UART_IN_LOOPBACK_EN
  logic [CW-1:0] dropCnt_q, dropCnt_d;

  // Loopback owns the write port; during reset the pointers are equal so only ~reset forces ready.
  assign push_ready = ~reset | (~full & ~uart_out_valid);
  assign doWrite    = ~full & (uart_out_valid | push_valid);
  assign wrData     = uart_out_valid ? uart_out_ch : push_data;
  assign doDrop     = uart_out_valid & full;

  always_comb begin
    dropCnt_d = dropCnt_q;
    if (doDrop && !(&dropCnt_q)) begin
      dropCnt_d = dropCnt_q + CntOne;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      dropCnt_q <= '0;
    end else begin
      dropCnt_q <= dropCnt_d;
    end
  end

  assign drop_cnt = dropCnt_q;
`else
  logic unused_loopback;

  assign push_ready      = ~full;
  assign doWrite         = push_valid & ~full;
  assign wrData          = push_data;
  assign doDrop          = 1'b0;
  assign drop_cnt        = '0;
  assign unused_loopback = ^{uart_out_valid, uart_out_ch, doDrop};
`endif

  // Response comes straight from registered state, never from the request strobe.
  assign uart_in_ch    = empty ? EMPTY_CH : mem_q[rdPtr_q[AW-1:0]];
  assign count         = wrPtr_q - rdPtr_q;
  assign underflow_cnt = underflowCnt_q;

  always_comb begin
    rdPtr_d        = rdPtr_q;
    wrPtr_d        = wrPtr_q;
    underflowCnt_d = underflowCnt_q;
    if (doPop) begin
      rdPtr_d = rdPtr_q + PtrOne;
    end
    if (doWrite) begin
      wrPtr_d = wrPtr_q + PtrOne;
    end
    if (uart_in_valid && empty && !(&underflowCnt_q)) begin
      underflowCnt_d = underflowCnt_q + CntOne;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rdPtr_q        <= '0;
      wrPtr_q        <= '0;
      underflowCnt_q <= '0;
    end else begin
      rdPtr_q        <= rdPtr_d;
      wrPtr_q        <= wrPtr_d;
      underflowCnt_q <= underflowCnt_d;
    end
  end

  always_ff @(posedge clock) begin
    if (doWrite) begin
      mem_q[wrPtr_q[AW-1:0]] <= wrData;
    end
  end

endmodule
